arbitro_rr4: RTL and testbench

- Round-robin arbiter for the transaction layer.
- Drains four input FIFOs (0..3) into one downstream FIFO.
- Issues the pop_0..pop_3 strobes that the packet counters monitor, and produces a single push/data stream.
- Exports idle, which the counter-readback logic uses to know traffic has stopped.

---
 rtl/arbitro_rr4.sv | 155 +++++++++++++++
 tb/tb_arbitro_rr4.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_rr4.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : arbitro_rr4                                                     |
// | Purpose  : Four-way round-robin arbiter draining input FIFOs 0..3 into one |
// |            downstream FIFO with a fixed pop -> push latency of two cycles. |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module arbitro_rr4 #(
  parameter int unsigned DATA_WIDTH = 10,
  parameter logic [1:0]  START_PTR  = 2'd3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  empty_FIFO_0,
  input  logic                  empty_FIFO_1,
  input  logic                  empty_FIFO_2,
  input  logic                  empty_FIFO_3,
  input  logic [DATA_WIDTH-1:0] data_out_FIFO_0,
  input  logic [DATA_WIDTH-1:0] data_out_FIFO_1,
  input  logic [DATA_WIDTH-1:0] data_out_FIFO_2,
  input  logic [DATA_WIDTH-1:0] data_out_FIFO_3,
  input  logic                  almost_full,
  input  logic                  enable,
  output logic                  pop_0,
  output logic                  pop_1,
  output logic                  pop_2,
  output logic                  pop_3,
  output logic                  push,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  idle,
  output logic [1:0]            state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACTIVE = 2'b01,
    ST_STALL  = 2'b10
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0]              last_ptr_q, last_ptr_d;
  logic [3:0]              pop_q, pop_d;
  logic                    v1_q, v1_d;       // a word is being read out of an input FIFO this cycle
  logic [1:0]              sel1_q, sel1_d;   // which FIFO that word comes from
  logic                    push_q, push_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    idle_q, idle_d;

  logic [3:0]              empty_vec;
  logic [3:0]              elig;
  logic                    grant_found;
  logic [1:0]              grant_idx;
  logic                    grant_ok;
  logic                    pipe_empty;

  assign empty_vec  = {empty_FIFO_3, empty_FIFO_2, empty_FIFO_1, empty_FIFO_0};
  // A FIFO popped this cycle still shows its stale empty flag, so skip it once.
  assign elig       = ~empty_vec & ~pop_q;
  assign pipe_empty = (pop_q == 4'b0000) && !v1_q;
  assign grant_ok   = grant_found && enable && !almost_full && (state_q != ST_STALL);

  // Rotating-priority search starting just after the last granted FIFO.
  always_comb begin
    logic [1:0] cand;
    grant_found = 1'b0;
    grant_idx   = last_ptr_q;
    cand        = last_ptr_q;
    for (int i = 1; i <= 4; i++) begin
      cand = last_ptr_q + 2'(i);
      if (!grant_found && elig[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Next-state decision for the arbitration FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (enable && !almost_full && (elig != 4'b0000)) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (almost_full) begin
          state_d = ST_STALL;
        end else if (((elig == 4'b0000) || !enable) && pipe_empty) begin
          state_d = ST_IDLE;
        end
      end
      ST_STALL: begin
        if (!almost_full) state_d = ST_ACTIVE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Grant, two-stage read pipeline and idle computation.
  always_comb begin
    pop_d      = 4'b0000;
    last_ptr_d = last_ptr_q;
    if (grant_ok) begin
      pop_d[grant_idx] = 1'b1;
      last_ptr_d       = grant_idx;
    end
    // While a pop is outstanding last_ptr_q already names the popped FIFO.
    v1_d   = (pop_q != 4'b0000);
    sel1_d = last_ptr_q;
    push_d = v1_q;
    data_d = data_q;
    if (v1_q) begin
      case (sel1_q)
        2'd0:    data_d = data_out_FIFO_0;
        2'd1:    data_d = data_out_FIFO_1;
        2'd2:    data_d = data_out_FIFO_2;
        default: data_d = data_out_FIFO_3;
      endcase
    end
    idle_d = (state_d == ST_IDLE) && (pop_d == 4'b0000) && !push_d && !v1_d;
  end

  // State and registered outputs; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      last_ptr_q <= START_PTR;
      pop_q      <= 4'b0000;
      v1_q       <= 1'b0;
      sel1_q     <= 2'd0;
      push_q     <= 1'b0;
      data_q     <= '0;
      idle_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      last_ptr_q <= last_ptr_d;
      pop_q      <= pop_d;
      v1_q       <= v1_d;
      sel1_q     <= sel1_d;
      push_q     <= push_d;
      data_q     <= data_d;
      idle_q     <= idle_d;
    end
  end

  assign pop_0    = pop_q[0];
  assign pop_1    = pop_q[1];
  assign pop_2    = pop_q[2];
  assign pop_3    = pop_q[3];
  assign push     = push_q;
  assign data_out = data_q;
  assign idle     = idle_q;
  assign state    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_arbitro_rr4.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_arbitro_rr4                                                  |
// | Purpose  : Self-checking bench for arbitro_rr4 with emulated input FIFOs   |
// |            and a rule-level reference model of the arbiter.                |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_arbitro_rr4;
  localparam int DW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          en  = 1'b1;
  logic          af  = 1'b0;
  logic [3:0]    emp = 4'hF;
  logic [DW-1:0] fd [4];
  logic          pop_0, pop_1, pop_2, pop_3, push, idle;
  logic [DW-1:0] data_out;
  logic [1:0]    state;

  arbitro_rr4 #(.DATA_WIDTH(DW), .START_PTR(2'd3)) dut (
    .clk(clk), .rst(rst),
    .empty_FIFO_0(emp[0]), .empty_FIFO_1(emp[1]), .empty_FIFO_2(emp[2]), .empty_FIFO_3(emp[3]),
    .data_out_FIFO_0(fd[0]), .data_out_FIFO_1(fd[1]), .data_out_FIFO_2(fd[2]), .data_out_FIFO_3(fd[3]),
    .almost_full(af), .enable(en),
    .pop_0(pop_0), .pop_1(pop_1), .pop_2(pop_2), .pop_3(pop_3),
    .push(push), .data_out(data_out), .idle(idle), .state(state)
  );

  // FIFO storage shared by the emulated FIFOs (frd) and the model (mrd).
  logic [DW-1:0] mem [4][1024];
  int            wr [4];
  int            frd[4];
  int            mrd[4];

  // Reference model: states 0=idle 1=active 2=stall, m_pop=-1 when none.
  int            m_state, m_last, m_pop;
  bit            m_v1, m_push, m_idle;
  logic [DW-1:0] m_v1w, m_data;
  logic [17:0]   exp_v;
  wire  [17:0]   obs_v = {pop_3, pop_2, pop_1, pop_0, push, data_out, idle, state};
  wire  [3:0]    pops  = {pop_3, pop_2, pop_1, pop_0};

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [3:0] onehot(int k);
    logic [3:0] r;
    r = 4'b0000;
    if (k >= 0) r[k] = 1'b1;
    return r;
  endfunction

  function automatic int idx_of(logic [3:0] p);
    int r;
    r = -1;
    for (int i = 0; i < 4; i++) if (p[i]) r = i;
    return r;
  endfunction

  task automatic load(int k, logic [DW-1:0] w);
    mem[k][wr[k]] = w;
    wr[k]++;
    emp[k] = 1'b0;
  endtask

  // One clock: advance the model from the inputs seen before the edge, then
  // let the emulated FIFOs react to the DUT's pop strobes.
  task automatic tick();
    logic       s_rst, s_en, s_af;
    logic [3:0] s_pop;
    int         cand, k, ns, np;
    bit         pe, g, nv1, npush;
    logic [DW-1:0] nv1w, nd;
    s_rst = rst; s_en = en; s_af = af; s_pop = pops;
    cand = -1;
    for (int i = 1; i <= 4; i++) begin
      k = (m_last + i) % 4;
      if (cand < 0 && mrd[k] < wr[k] && k != m_pop) cand = k;
    end
    pe    = (m_pop < 0) && !m_v1;
    npush = m_v1;
    nd    = m_v1 ? m_v1w : m_data;
    nv1   = (m_pop >= 0);
    nv1w  = m_v1w;
    if (m_pop >= 0) begin
      nv1w = mem[m_pop][mrd[m_pop]];
      mrd[m_pop]++;
    end
    g  = (cand >= 0) && s_en && !s_af && (m_state != 2);
    np = g ? cand : -1;
    ns = m_state;
    case (m_state)
      0: if (s_en && !s_af && cand >= 0) ns = 1;
      1: if (s_af) ns = 2; else if ((cand < 0 || !s_en) && pe) ns = 0;
      default: if (!s_af) ns = 1;
    endcase
    if (s_rst) begin
      m_state = 0; m_last = 3; m_pop = -1; m_v1 = 0; m_push = 0; m_data = '0; m_idle = 1;
    end else begin
      if (g) m_last = cand;
      m_state = ns; m_pop = np; m_v1 = nv1; m_v1w = nv1w; m_push = npush; m_data = nd;
      m_idle  = (ns == 0) && (np < 0) && !npush && !nv1;
    end
    exp_v = {onehot(m_pop), m_push, m_data, m_idle, 2'(m_state)};
    @(posedge clk);
    #1;
    for (int j = 0; j < 4; j++) begin
      if (s_pop[j] && frd[j] < wr[j]) begin
        fd[j] = mem[j][frd[j]];
        frd[j]++;
      end
      emp[j] = (frd[j] >= wr[j]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick(); n_cmp++;
      if (obs_v !== exp_v) begin n_err++; $display("FAIL reset_hold: got %h expected %h", obs_v, exp_v); end
    end
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick(); n_cmp++;
      if (obs_v !== exp_v) begin n_err++; $display("FAIL reset_model c%0d: got %h expected %h", c, obs_v, exp_v); end
      n_cmp++;
      if ({pops, push, idle, state} !== 8'b0000_0_1_00) begin
        n_err++; $display("FAIL reset_quiet c%0d: got pops=%b push=%b idle=%b state=%0d expected 0/0/1/0", c, pops, push, idle, state);
      end
    end
  endtask

  task automatic test_single_fifo();
    int pc[$];
    int hc[$];
    logic [DW-1:0] hd[$];
    load(0, 10'h001); load(0, 10'h002);
    for (int c = 0; c < 12; c++) begin
      tick(); n_cmp++;
      if (obs_v !== exp_v) begin n_err++; $display("FAIL single_model c%0d: got %h expected %h", c, obs_v, exp_v); end
      if (pop_0) pc.push_back(c);
      if (push) begin hc.push_back(c); hd.push_back(data_out); end
    end
    n_cmp++;
    if (pc.size() != 2 || hc.size() != 2) begin
      n_err++; $display("FAIL single_counts: got pops=%0d pushes=%0d expected 2/2", pc.size(), hc.size());
    end else begin
      n_cmp++;
      if (pc[1] - pc[0] != 2) begin n_err++; $display("FAIL single_pop_gap: got %0d expected 2", pc[1] - pc[0]); end
      n_cmp++;
      if (hc[0] != pc[0] + 2 || hc[1] != pc[0] + 4) begin
        n_err++; $display("FAIL single_push_time: got %0d,%0d expected %0d,%0d", hc[0], hc[1], pc[0] + 2, pc[0] + 4);
      end
      n_cmp++;
      if (hd[0] !== 10'h001 || hd[1] !== 10'h002) begin
        n_err++; $display("FAIL single_data: got %h,%h expected 001,002", hd[0], hd[1]);
      end
    end
    n_cmp++;
    if (idle !== 1'b1) begin n_err++; $display("FAIL single_idle: got %b expected 1", idle); end
  endtask

  task automatic test_round_robin();
    int pk[$];
    int pc[$];
    int hc[$];
    logic [DW-1:0] hd[$];
    logic [DW-1:0] w;
    rst = 1'b1;
    tick(); n_cmp++;
    if (obs_v !== exp_v) begin n_err++; $display("FAIL rr_reset: got %h expected %h", obs_v, exp_v); end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) for (int j = 0; j < 3; j++) load(k, 10'(10'h100 + k * 16 + j));
    for (int c = 0; c < 22; c++) begin
      tick(); n_cmp++;
      if (obs_v !== exp_v) begin n_err++; $display("FAIL rr_model c%0d: got %h expected %h", c, obs_v, exp_v); end
      if (pops != 4'b0000) begin pk.push_back(idx_of(pops)); pc.push_back(c); end
      if (push) begin hc.push_back(c); hd.push_back(data_out); end
    end
    n_cmp++;
    if (pk.size() != 12 || hd.size() != 12) begin
      n_err++; $display("FAIL rr_counts: got pops=%0d pushes=%0d expected 12/12", pk.size(), hd.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        w = 10'(10'h100 + (i % 4) * 16 + i / 4);
        n_cmp++;
        if (pk[i] != i % 4 || hd[i] !== w) begin
          n_err++; $display("FAIL rr_order i%0d: got fifo %0d data %h expected fifo %0d data %h", i, pk[i], hd[i], i % 4, w);
        end
      end
      n_cmp++;
      if (pc[11] - pc[0] != 11 || hc[11] - hc[0] != 11 || hc[0] != pc[0] + 2) begin
        n_err++; $display("FAIL rr_rate: got pop span %0d push span %0d lag %0d expected 11/11/2", pc[11] - pc[0], hc[11] - hc[0], hc[0] - pc[0]);
      end
    end
    n_cmp++;
    if (idle !== 1'b1) begin n_err++; $display("FAIL rr_idle: got %b expected 1", idle); end
  endtask

  task automatic drain(string nm);
    en = 1'b1; af = 1'b0;
    for (int c = 0; c < 80; c++) begin
      tick(); n_cmp++;
      if (obs_v !== exp_v) begin n_err++; $display("FAIL %s_drain c%0d: got %h expected %h", nm, c, obs_v, exp_v); end
      if (idle && emp == 4'hF) break;
    end
    n_cmp++;
    if (idle !== 1'b1 || emp !== 4'hF) begin n_err++; $display("FAIL %s_timeout: got idle=%b emp=%b expected 1/1111", nm, idle, emp); end
  endtask

  task automatic test_stall();
    int last, npush, npop, first;
    bit saw;
    last = -1; npush = 0; npop = 0; first = -1; saw = 0;
    for (int k = 0; k < 4; k++) for (int j = 0; j < 4; j++) load(k, 10'(10'h200 + k * 16 + j));
    for (int c = 0; c < 5; c++) begin
      tick(); n_cmp++;
      if (obs_v !== exp_v) begin n_err++; $display("FAIL stall_pre c%0d: got %h expected %h", c, obs_v, exp_v); end
      if (pops != 4'b0000) last = idx_of(pops);
    end
    af = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick(); n_cmp++;
      if (obs_v !== exp_v) begin n_err++; $display("FAIL stall_af c%0d: got %h expected %h", c, obs_v, exp_v); end
      if (push) npush++;
      if (pops != 4'b0000) npop++;
      if (state == 2'd2) saw = 1;
    end
    n_cmp++;
    if (npush != 2 || npop != 0 || !saw) begin
      n_err++; $display("FAIL stall_window: got pushes=%0d pops=%0d stall_seen=%0d expected 2/0/1", npush, npop, saw);
    end
    af = 1'b0;
    for (int c = 0; c < 4 && first < 0; c++) begin
      tick(); n_cmp++;
      if (obs_v !== exp_v) begin n_err++; $display("FAIL stall_resume c%0d: got %h expected %h", c, obs_v, exp_v); end
      if (pops != 4'b0000) first = idx_of(pops);
    end
    n_cmp++;
    if (first != (last + 1) % 4) begin n_err++; $display("FAIL stall_next: got fifo %0d expected fifo %0d", first, (last + 1) % 4); end
    drain("stall");
  endtask

  task automatic test_enable();
    en = 1'b0;
    for (int k = 0; k < 4; k++) load(k, 10'(10'h300 + k));
    for (int c = 0; c < 5; c++) begin
      tick(); n_cmp++;
      if (obs_v !== exp_v) begin n_err++; $display("FAIL en_off_model c%0d: got %h expected %h", c, obs_v, exp_v); end
      n_cmp++;
      if (pops !== 4'b0000 || idle !== 1'b1) begin n_err++; $display("FAIL en_off c%0d: got pops=%b idle=%b expected 0000/1", c, pops, idle); end
    end
    en = 1'b1;
    tick(); n_cmp++;
    if (obs_v !== exp_v) begin n_err++; $display("FAIL en_on_model: got %h expected %h", obs_v, exp_v); end
    n_cmp++;
    if (pops == 4'b0000) begin n_err++; $display("FAIL en_first_pop: got pops=%b expected one pop", pops); end
    drain("enable");
  endtask

  task automatic test_reset_inflight();
    int first;
    first = -1;
    for (int k = 0; k < 4; k++) for (int j = 0; j < 3; j++) load(k, 10'(10'h040 + k * 4 + j));
    for (int c = 0; c < 3; c++) begin
      tick(); n_cmp++;
      if (obs_v !== exp_v) begin n_err++; $display("FAIL rstf_pre c%0d: got %h expected %h", c, obs_v, exp_v); end
    end
    rst = 1'b1;
    tick(); n_cmp++;
    if (obs_v !== exp_v) begin n_err++; $display("FAIL rstf_model: got %h expected %h", obs_v, exp_v); end
    n_cmp++;
    if (push !== 1'b0 || pops !== 4'b0000 || idle !== 1'b1) begin
      n_err++; $display("FAIL rstf_clear: got push=%b pops=%b idle=%b expected 0/0000/1", push, pops, idle);
    end
    rst = 1'b0;
    for (int c = 0; c < 4 && first < 0; c++) begin
      tick(); n_cmp++;
      if (obs_v !== exp_v) begin n_err++; $display("FAIL rstf_post c%0d: got %h expected %h", c, obs_v, exp_v); end
      if (pops != 4'b0000) first = idx_of(pops);
    end
    n_cmp++;
    if (first != 0) begin n_err++; $display("FAIL rstf_first_grant: got fifo %0d expected fifo 0", first); end
    drain("rstf");
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 4; k++) begin
        int n;
        n = int'($urandom_range(0, 5));
        for (int j = 0; j < n; j++) load(k, 10'($urandom_range(0, 1023)));
      end
      for (int c = 0; c < 40; c++) begin
        en = ($urandom_range(0, 3) != 0);
        af = ($urandom_range(0, 4) == 0);
        tick(); n_cmp++;
        if (obs_v !== exp_v) begin n_err++; $display("FAIL rand_model r%0d c%0d: got %h expected %h", r, c, obs_v, exp_v); end
      end
      drain("rand");
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      wr[k] = 0; frd[k] = 0; mrd[k] = 0; fd[k] = '0;
    end
    m_state = 0; m_last = 3; m_pop = -1; m_v1 = 0; m_push = 0; m_idle = 1;
    m_v1w = '0; m_data = '0; exp_v = '0;
    test_reset();
    test_single_fifo();
    test_round_robin();
    test_stall();
    test_enable();
    test_reset_inflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
